// File: rtl/ram_lsu_pkg.sv
// Shared definitions for the RAM load/store unit: funct3 codes, FSM encoding, size decode.
package ram_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} lsuState_e;

  // Access width in bytes from funct3[1:0]; code 3 is illegal and rejected elsewhere.
  function automatic logic [2:0] sizeDecode(input logic [1:0] sizeCode);
    case (sizeCode)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store shift/byte-mask generation and load extract/extend.
module lsu_align
  import ram_lsu_pkg::*;
(
  input  logic [31:0] storeData,
  input  logic [1:0]  storeOff,
  input  logic [2:0]  storeSize,
  output logic [63:0] storeImage,
  output logic [7:0]  storeMask,
  input  logic [31:0] loadLo,
  input  logic [31:0] loadHi,
  input  logic [1:0]  loadOff,
  input  logic [2:0]  loadFunct3,
  output logic [31:0] loadData
);

  logic [31:0] shifted;

  always_comb begin
    storeImage = {32'd0, storeData} << {storeOff, 3'b000};
    storeMask  = ((8'd1 << storeSize) - 8'd1) << storeOff;
    shifted    = 32'({loadHi, loadLo} >> {loadOff, 3'b000});
    case (loadFunct3)
      F3_B:    loadData = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    loadData = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   loadData = {24'd0, shifted[7:0]};
      F3_HU:   loadData = {16'd0, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

endmodule

// File: rtl/ram_lsu.sv
// Single-outstanding RV32 load/store initiator for the word-addressed data RAM.
// Define LSU_MISALIGN_SPLIT_EN to run word-crossing accesses as two RAM beats.
module ram_lsu
  import ram_lsu_pkg::*;
(
  input  logic        iLSU_CLK,
  input  logic        iLSU_RST_N,
  input  logic        iLSU_VALID,
  output logic        oLSU_READY,
  input  logic        iLSU_WE,
  input  logic [2:0]  iLSU_FUNCT3,
  input  logic [31:0] iLSU_ADDR,
  input  logic [31:0] iLSU_WDATA,
  output logic        oLSU_RVALID,
  output logic [31:0] oLSU_RDATA,
  output logic        oLSU_ERR,
  output logic        oRAM_CE,
  output logic        oRAM_RD,
  output logic        oRAM_WR,
  output logic [3:0]  oRAM_WSTRB,
  output logic [31:0] oREAD_ADDR,
  output logic [31:0] oWRITE_ADDR,
  output logic [31:0] oRAM_WDATA,
  input  logic [31:0] iRAM_DATA
);

  lsuState_e   stateQ, stateD;
  logic        reqWeQ, errQ;
  logic [2:0]  reqF3Q;
  logic [1:0]  reqOffQ;
  logic [31:0] loWordQ, hiWord;
  logic        ceQ, ceD, rdQ, rdD, wrQ, wrD;
  logic [3:0]  wstrbQ, wstrbD;
  logic [31:0] readAddrQ, readAddrD, writeAddrQ, writeAddrD, wdataQ, wdataD;

  logic        accept, misaligned, illegal, fail;
  logic [2:0]  size;
  logic [3:0]  endOff;
  logic [63:0] storeImage;
  logic [7:0]  storeMask;
  logic [31:0] loadData;

  assign accept     = (stateQ == StIdle) & iLSU_VALID;
  assign size       = sizeDecode(iLSU_FUNCT3[1:0]);
  assign endOff     = {2'b00, iLSU_ADDR[1:0]} + {1'b0, size};
  assign misaligned = endOff > 4'd4;
  assign illegal    = iLSU_WE ? (iLSU_FUNCT3 > F3_W)
                              : (iLSU_FUNCT3 == 3'd3 || iLSU_FUNCT3[2:1] == 2'b11);

  lsu_align u_align (
    .storeData  (iLSU_WDATA),
    .storeOff   (iLSU_ADDR[1:0]),
    .storeSize  (size),
    .storeImage (storeImage),
    .storeMask  (storeMask),
    .loadLo     (loWordQ),
    .loadHi     (hiWord),
    .loadOff    (reqOffQ),
    .loadFunct3 (reqF3Q),
    .loadData   (loadData)
  );

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        misQ;
  logic [29:0] wordAQ;
  logic [3:0]  hiStrbQ;
  logic [31:0] hiDataQ, hiWordQ;

  assign fail   = illegal;
  assign hiWord = hiWordQ;

  // Upper half of the store image is held for the second beat.
  always_ff @(posedge iLSU_CLK or negedge iLSU_RST_N) begin
    if (!iLSU_RST_N) begin
      misQ    <= 1'b0;
      wordAQ  <= '0;
      hiStrbQ <= '0;
      hiDataQ <= '0;
      hiWordQ <= '0;
    end else begin
      if (accept) begin
        misQ    <= misaligned;
        wordAQ  <= iLSU_ADDR[31:2];
        hiStrbQ <= storeMask[7:4];
        hiDataQ <= storeImage[63:32];
      end
      if (stateQ == StBeat1) hiWordQ <= iRAM_DATA;
    end
  end
`else
  logic unusedHi;

  assign fail     = illegal | misaligned;
  assign hiWord   = '0;
  assign unusedHi = ^{storeMask[7:4], storeImage[63:32]};
`endif

  always_comb begin
    stateD     = stateQ;
    ceD        = 1'b0;
    rdD        = 1'b0;
    wrD        = 1'b0;
    wstrbD     = '0;
    readAddrD  = '0;
    writeAddrD = '0;
    wdataD     = '0;
    case (stateQ)
      StIdle: begin
        if (iLSU_VALID) begin
          if (fail) begin
            stateD = StResp;
          end else begin
            stateD = StBeat0;
            ceD    = 1'b1;
            rdD    = ~iLSU_WE;
            wrD    = iLSU_WE;
            if (iLSU_WE) begin
              writeAddrD = {2'b00, iLSU_ADDR[31:2]};
              wstrbD     = storeMask[3:0];
              wdataD     = storeImage[31:0];
            end else begin
              readAddrD  = {2'b00, iLSU_ADDR[31:2]};
            end
          end
        end
      end
      StBeat0: begin
        stateD = StResp;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (misQ) begin
          stateD = StBeat1;
          ceD    = 1'b1;
          rdD    = ~reqWeQ;
          wrD    = reqWeQ;
          if (reqWeQ) begin
            writeAddrD = {2'b00, wordAQ + 30'd1};
            wstrbD     = hiStrbQ;
            wdataD     = hiDataQ;
          end else begin
            readAddrD  = {2'b00, wordAQ + 30'd1};
          end
        end
`endif
      end
      StBeat1: stateD = StResp;
      StResp:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge iLSU_CLK or negedge iLSU_RST_N) begin
    if (!iLSU_RST_N) begin
      stateQ     <= StIdle;
      reqWeQ     <= 1'b0;
      errQ       <= 1'b0;
      reqF3Q     <= '0;
      reqOffQ    <= '0;
      loWordQ    <= '0;
      ceQ        <= 1'b0;
      rdQ        <= 1'b0;
      wrQ        <= 1'b0;
      wstrbQ     <= '0;
      readAddrQ  <= '0;
      writeAddrQ <= '0;
      wdataQ     <= '0;
    end else begin
      stateQ     <= stateD;
      ceQ        <= ceD;
      rdQ        <= rdD;
      wrQ        <= wrD;
      wstrbQ     <= wstrbD;
      readAddrQ  <= readAddrD;
      writeAddrQ <= writeAddrD;
      wdataQ     <= wdataD;
      if (accept) begin
        reqWeQ  <= iLSU_WE;
        errQ    <= fail;
        reqF3Q  <= iLSU_FUNCT3;
        reqOffQ <= iLSU_ADDR[1:0];
      end
      if (stateQ == StBeat0) loWordQ <= iRAM_DATA;
    end
  end

  assign oLSU_READY  = (stateQ == StIdle) & iLSU_RST_N;
  assign oLSU_RVALID = (stateQ == StResp);
  assign oLSU_ERR    = oLSU_RVALID & errQ;
  assign oLSU_RDATA  = (oLSU_RVALID & ~errQ & ~reqWeQ) ? loadData : '0;
  assign oRAM_CE     = ceQ;
  assign oRAM_RD     = rdQ;
  assign oRAM_WR     = wrQ;
  assign oRAM_WSTRB  = wstrbQ;
  assign oREAD_ADDR  = readAddrQ;
  assign oWRITE_ADDR = writeAddrQ;
  assign oRAM_WDATA  = wdataQ;

endmodule

// File: tb/tb_ram_lsu.sv
// Bench for ram_lsu: byte-array reference model, directed cases then random accesses.
module tb_ram_lsu;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        lsuValid = 1'b0;
  logic        lsuWe = 1'b0;
  logic [2:0]  lsuFunct3 = '0;
  logic [31:0] lsuAddr = '0;
  logic [31:0] lsuWdata = '0;
  logic        lsuReady, rvalid, err;
  logic [31:0] rdata;
  logic        ramCe, ramRd, ramWr;
  logic [3:0]  ramWstrb;
  logic [31:0] rdAddr, wrAddr, ramWdata, ramData;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] ram [64];
  logic        seed = 1'b1;
  logic [7:0]  refMem [256];

  logic [31:0] lastData;
  logic        lastErr;
  int          lastLat, lastBeats;
  logic [3:0]  lastStrb [2];
  logic [31:0] lastWord [2];

  always #5 clk = ~clk;

  ram_lsu dut (
    .iLSU_CLK    (clk),
    .iLSU_RST_N  (rstN),
    .iLSU_VALID  (lsuValid),
    .oLSU_READY  (lsuReady),
    .iLSU_WE     (lsuWe),
    .iLSU_FUNCT3 (lsuFunct3),
    .iLSU_ADDR   (lsuAddr),
    .iLSU_WDATA  (lsuWdata),
    .oLSU_RVALID (rvalid),
    .oLSU_RDATA  (rdata),
    .oLSU_ERR    (err),
    .oRAM_CE     (ramCe),
    .oRAM_RD     (ramRd),
    .oRAM_WR     (ramWr),
    .oRAM_WSTRB  (ramWstrb),
    .oREAD_ADDR  (rdAddr),
    .oWRITE_ADDR (wrAddr),
    .oRAM_WDATA  (ramWdata),
    .iRAM_DATA   (ramData)
  );

  // RAM: combinational read, byte-strobed write; seeded with byte j = j ^ 0x5A.
  assign ramData = ram[rdAddr[5:0]];
  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 64; i++)
        for (int b = 0; b < 4; b++) ram[i][8*b+:8] <= 8'(4*i + b) ^ 8'h5A;
    end else if (ramCe && ramWr) begin
      for (int b = 0; b < 4; b++)
        if (ramWstrb[b]) ram[wrAddr[5:0]][8*b+:8] <= ramWdata[8*b+:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request, started at a negedge; returns at the negedge after the response.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    int size, off, expBeats;
    logic illegal, mis, expErr, ctlOk;
    logic [31:0] raw, expData;
    size     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off      = int'(addr[1:0]);
    mis      = (off + size) > 4;
    illegal  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    expErr   = illegal || (mis && !SplitEn);
    expBeats = expErr ? 0 : (mis ? 2 : 1);
    expData  = '0;
    if (!expErr) begin
      if (we) begin
        for (int i = 0; i < size; i++) refMem[int'(addr[7:0]) + i] = wd[8*i+:8];
      end else begin
        raw = '0;
        for (int i = 0; i < size; i++) raw[8*i+:8] = refMem[int'(addr[7:0]) + i];
        if (f3 == 3'd0)      expData = {{24{raw[7]}}, raw[7:0]};
        else if (f3 == 3'd1) expData = {{16{raw[15]}}, raw[15:0]};
        else                 expData = raw;
      end
    end

    lsuValid = 1'b1; lsuWe = we; lsuFunct3 = f3; lsuAddr = addr; lsuWdata = wd;
    check({tag, ":ready"}, 32'(lsuReady), 32'd1);
    @(posedge clk); #1;
    lsuValid = 1'b0; lsuAddr = $urandom(); lsuWdata = $urandom();
    lastLat = 0; lastBeats = 0; lastData = '0; lastErr = 1'b0; ctlOk = 1'b1;
    lastStrb[0] = '0; lastStrb[1] = '0; lastWord[0] = '0; lastWord[1] = '0;
    for (int k = 1; k <= 6 && lastLat == 0; k++) begin
      @(negedge clk);
      if (ramCe) begin
        if (lastBeats < 2) begin
          lastStrb[lastBeats] = ramWstrb;
          lastWord[lastBeats] = we ? wrAddr : rdAddr;
        end
        lastBeats++;
        if (ramRd !== !we || ramWr !== we) ctlOk = 1'b0;
      end else if (ramRd || ramWr || ramWstrb != 4'd0) begin
        ctlOk = 1'b0;
      end
      if (rvalid) begin
        lastLat = k; lastData = rdata; lastErr = err;
      end
    end
    @(negedge clk);
    check({tag, ":lat"}, 32'(lastLat), 32'(expBeats + 1));
    check({tag, ":err"}, 32'(lastErr), 32'(expErr));
    check({tag, ":rdata"}, lastData, expData);
    check({tag, ":beats"}, 32'(lastBeats), 32'(expBeats));
    check({tag, ":ctl"}, 32'(ctlOk), 32'd1);
    check({tag, ":oneshot"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    int rvSeen;
    for (int j = 0; j < 256; j++) refMem[j] = 8'(j) ^ 8'h5A;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(lsuReady), 32'd0);
    check("rst_ctl", 32'({ramCe, ramRd, ramWr, ramWstrb, rvalid, err}), 32'd0);
    check("rst_addr", rdAddr | wrAddr | ramWdata | rdata, 32'd0);
    seed = 1'b0;
    rstN = 1'b1;
    #1 check("rel_ready", 32'(lsuReady), 32'd1);

    access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10");
    check("sw10_word", lastWord[0], 32'd4);
    check("sw10_strb", 32'(lastStrb[0]), 32'hF);
    access(1'b0, 3'd2, 32'h10, 32'h0, "lw10");
    check("lw10_val", lastData, 32'hDEADBEEF);

    access(1'b1, 3'd0, 32'h13, 32'h00000080, "sb13");
    check("sb13_strb", 32'(lastStrb[0]), 32'h8);
    check("sb13_word", lastWord[0], 32'd4);
    access(1'b0, 3'd0, 32'h13, 32'h0, "lb13");
    check("lb13_val", lastData, 32'hFFFFFF80);
    access(1'b0, 3'd4, 32'h13, 32'h0, "lbu13");
    check("lbu13_val", lastData, 32'h00000080);

    access(1'b1, 3'd1, 32'h16, 32'h00001234, "sh16");
    check("sh16_strb", 32'(lastStrb[0]), 32'hC);
    check("sh16_word", lastWord[0], 32'd5);
    check("sh16_ram", 32'(ram[5][31:16]), 32'h1234);
    access(1'b0, 3'd1, 32'h16, 32'h0, "lh16");
    check("lh16_val", lastData, 32'h00001234);

    access(1'b1, 3'd2, 32'h0F, 32'hAABBCCDD, "sw0f");
    check("sw0f_err", 32'(lastErr), SplitEn ? 32'd0 : 32'd1);
    check("sw0f_w0", lastWord[0], SplitEn ? 32'd3 : 32'd0);
    check("sw0f_s0", 32'(lastStrb[0]), SplitEn ? 32'h8 : 32'h0);
    check("sw0f_w1", lastWord[1], SplitEn ? 32'd4 : 32'd0);
    check("sw0f_s1", 32'(lastStrb[1]), SplitEn ? 32'h7 : 32'h0);
    access(1'b0, 3'd2, 32'h0F, 32'h0, "lw0f");
    check("lw0f_val", lastData, SplitEn ? 32'hAABBCCDD : 32'h0);
    check("lw0f_lat", 32'(lastLat), SplitEn ? 32'd3 : 32'd1);

    access(1'b0, 3'd3, 32'h20, 32'h0, "ld_f3");
    check("ld_f3_err", 32'(lastErr), 32'd1);

    // Reset in the last beat of a store: split crosses words 8/9, otherwise aligned at word 8.
    lsuValid = 1'b1; lsuWe = 1'b1; lsuFunct3 = 3'd2;
    lsuAddr = SplitEn ? 32'h21 : 32'h20; lsuWdata = 32'h11223344;
    @(posedge clk); #1 lsuValid = 1'b0;
    @(negedge clk);
    if (SplitEn) @(negedge clk);
    check("rstmid_ce", 32'(ramCe), 32'd1);
    rstN = 1'b0;
    #1;
    check("rstmid_ready", 32'(lsuReady), 32'd0);
    check("rstmid_ctl", 32'({ramCe, ramRd, ramWr, ramWstrb, rvalid, err}), 32'd0);
    check("rstmid_bus", rdAddr | wrAddr | ramWdata | rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1 check("rstrel_ready", 32'(lsuReady), 32'd1);
    rvSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid) rvSeen++;
    end
    check("rstrel_norv", 32'(rvSeen), 32'd0);
    if (SplitEn) begin
      refMem[8'h21] = 8'h44; refMem[8'h22] = 8'h33; refMem[8'h23] = 8'h22;
    end
    access(1'b0, 3'd2, 32'h20, 32'h0, "rst_w8");
    access(1'b0, 3'd2, 32'h24, 32'h0, "rst_w9");

    for (int n = 0; n < 300; n++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 247)),
             $urandom(), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_lsu.md
# ram_lsu

Load/store initiator for the SoC's word-addressed data RAM, which has a combinational read and a byte-strobed synchronous write. It sits between the core's memory stage and the RAM port. It accepts one byte-addressed RV32 load/store at a time and drives the RAM's CE/RD/WR/WSTRB/address/data pins. It returns aligned, sign- or zero-extended load data, or a store acknowledge, with an error flag.

## Interface
- No parameters; RAM word address = byte address >> 2, full 30-bit index, upper 2 bits zero.
- iLSU_CLK  in  1  single clock; all state changes on rising edge
- iLSU_RST_N  in  1  asynchronous, active-low reset
- iLSU_VALID  in  1  request valid
- oLSU_READY  out  1  request accepted when VALID & READY
- iLSU_WE  in  1  1 = store, 0 = load
- iLSU_FUNCT3  in  3  RV32 funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
- iLSU_ADDR  in  32  byte address
- iLSU_WDATA  in  32  store data, right-justified
- oLSU_RVALID  out  1  one-cycle response strobe (loads and stores)
- oLSU_RDATA  out  32  extended load data; 0 for stores/errors
- oLSU_ERR  out  1  valid with RVALID: illegal funct3 or unsupported misalignment
- oRAM_CE, oRAM_RD, oRAM_WR  out  1 each  RAM controls
- oRAM_WSTRB  out  4  byte-lane write strobes
- oREAD_ADDR, oWRITE_ADDR  out  32 each  RAM word indices
- oRAM_WDATA  out  32  lane-positioned write data
- iRAM_DATA  in  32  RAM read word (combinational from oREAD_ADDR)

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- READY = (state==IDLE) & iLSU_RST_N.
- On accept, register the request and decode it:
  - off = ADDR[1:0]; size = 1/2/4 bytes from FUNCT3[1:0].
  - misaligned when off+size > 4.
  - illegal: FUNCT3 in {3,6,7} for loads; FUNCT3 > 2 for stores.
- Illegal, or misaligned without split support: IDLE→RESP, ERR=1, no RAM pins asserted.
- Otherwise IDLE→BEAT0. From BEAT0: →BEAT1 if misaligned, else →RESP. BEAT1→RESP. RESP→IDLE.
- Lane math:
  - 64-bit store image = WDATA << 8·off; 8-bit mask = ((1<<size)−1) << off.
  - BEAT0 uses word A = ADDR>>2 with low mask/data; BEAT1 uses A+1 (mod 2^30) with high mask/data.
- Beats: CE=1, plus RD=1 for loads or WR=1 for stores.
  - Loads: iRAM_DATA captured at end of beat into lo (BEAT0) / hi (BEAT1) word.
  - Result = ({hi,lo} >> 8·off) truncated to size, then sign-extended (B,H) or zero-extended (BU,HU,W).
- When no beat is active, all RAM outputs = 0; addresses, strobes and data are registered (no input-to-RAM combinational path).
- RESP: RVALID=1 for exactly one cycle; RDATA/ERR valid only then.

## Timing
- Accept at cycle N.
- Aligned access: beat at N+1, RVALID at N+2.
- Split access: beats N+1, N+2, RVALID at N+3.
- Error: RVALID at N+1.
- Store bytes are visible in RAM from the edge ending each beat; a subsequent load observes them.
- Next accept no earlier than the cycle after RESP (IDLE). Back-to-back aligned throughput: one access per 3 cycles.
- Reset assertion at any time → IDLE immediately.
  - All outputs 0 except READY, which is 0 while reset is held and 1 after release.
  - A split store interrupted after BEAT0 leaves the first word written; no response is issued.
- Capture registers reset to 0.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: misaligned H/W accesses (including word-boundary crossings) execute as two beats.
- LSU_MISALIGN_SPLIT_EN undefined: BEAT1 is not built; misaligned accesses return ERR=1 at N+1 with no RAM activity.

## Structure
- ram_lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state encoding;
  - a size-decode function.
- Sub-module lsu_align (combinational) implements the store shift/mask generation and the load extract/extend; the FSM and registers stay in ram_lsu.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → WR beat word 4 with WSTRB=1111; load RDATA=0xDEADBEEF at N+2, ERR=0.
- SB 0x80 @0x13, then LB and LBU @0x13 → WSTRB=1000 at word 4; RDATA=0xFFFFFF80 and 0x00000080 respectively.
- SH 0x1234 @0x16 → WSTRB=1100 on word 5, RAM word 5 [31:16]=0x1234; LH @0x16 → 0x00001234.
- With split: SW 0xAABBCCDD @0x0F → beat0 word 3 WSTRB=1000 (byte 0xDD), beat1 word 4 WSTRB=0111; LW @0x0F → 0xAABBCCDD at N+3. Without split: ERR=1 at N+1, RAM pins idle.
- Load with FUNCT3=3 → RVALID at N+1, ERR=1, RDATA=0, CE never asserted.
- Reset pulse during BEAT1 of a split store → outputs 0 immediately; after release READY=1, no RVALID, first word updated, second unchanged.
